// File: rtl/dac_spi_writer.sv
// Serial back end for the DAC command path: shifts 16-bit words MSB-first
// over SCLK/DIN/SYNC_n with a one-deep pending buffer and busy/done/overrun flags.
module dac_spi_writer #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_dac,
  input  logic [DATA_W-1:0] dato_dac,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic              dac_sync_n
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t            state, state_n;
  logic [TW-1:0]     tmr, tmr_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic              low_half, low_half_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] pend, pend_n;
  logic              pend_v, pend_v_n;
  logic              busy_n, done_n, overrun_n;
  logic              sclk_n, din_n, sync_n_n;
  logic              tmr_last;
  logic              gap_end;
  logic              in_frame;

  assign tmr_last = (tmr == T_LAST);
  assign gap_end  = (state == GAP) && tmr_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tmr        <= '0;
      bit_cnt    <= '0;
      low_half   <= 1'b0;
      shreg      <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      dac_sclk   <= 1'b1;
      dac_din    <= 1'b0;
      dac_sync_n <= 1'b1;
    end else begin
      state      <= state_n;
      tmr        <= tmr_n;
      bit_cnt    <= bit_cnt_n;
      low_half   <= low_half_n;
      shreg      <= shreg_n;
      pend       <= pend_n;
      pend_v     <= pend_v_n;
      busy       <= busy_n;
      done       <= done_n;
      overrun    <= overrun_n;
      dac_sclk   <= sclk_n;
      dac_din    <= din_n;
      dac_sync_n <= sync_n_n;
    end
  end

  always_comb begin
    state_n    = state;
    tmr_n      = tmr_last ? '0 : tmr + TW'(1);
    bit_cnt_n  = bit_cnt;
    low_half_n = low_half;
    shreg_n    = shreg;
    pend_n     = pend;
    pend_v_n   = pend_v;
    done_n     = 1'b0;
    overrun_n  = 1'b0;

    case (state)
      IDLE: begin
        tmr_n = '0;
        if (ctrl_dac) begin
          shreg_n    = dato_dac;
          state_n    = SETUP;
          bit_cnt_n  = '0;
          low_half_n = 1'b0;
        end
      end
      SETUP: begin
        if (tmr_last) state_n = SHIFT;
      end
      SHIFT: begin
        if (tmr_last) begin
          if (!low_half) begin
            low_half_n = 1'b1;
          end else begin
            low_half_n = 1'b0;
            if (bit_cnt == B_LAST) begin
              state_n = HOLD;
            end else begin
              bit_cnt_n = bit_cnt + BW'(1);
              shreg_n   = shreg << 1;
            end
          end
        end
      end
      HOLD: begin
        if (tmr_last) begin
          state_n = GAP;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        if (tmr_last) begin
          // pending word wins; a strobe on this edge refills the buffer
          if (pend_v) begin
            shreg_n    = pend;
            state_n    = SETUP;
            bit_cnt_n  = '0;
            low_half_n = 1'b0;
            pend_v_n   = ctrl_dac;
            if (ctrl_dac) pend_n = dato_dac;
          end else if (ctrl_dac) begin
            shreg_n    = dato_dac;
            state_n    = SETUP;
            bit_cnt_n  = '0;
            low_half_n = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (ctrl_dac && state != IDLE && !gap_end) begin
      pend_n    = dato_dac;
      pend_v_n  = 1'b1;
      overrun_n = pend_v;
    end
  end

  always_comb begin
    in_frame = (state_n == SETUP) || (state_n == SHIFT) ||
               (state_n == HOLD);
    sync_n_n = !in_frame;
    sclk_n   = !((state_n == SHIFT) && low_half_n);
    din_n    = in_frame && shreg_n[DATA_W-1];
    busy_n   = (state_n != IDLE) || pend_v_n;
  end

endmodule
